// File: rtl/action_scheduler_pkg.sv
// Shared command/action encoding between the input front-end, the scheduler
// and the game engine, plus the scheduler's own FSM states.
package enum_type;

  typedef enum logic [3:0] {
    NONE,
    LEFT,
    RIGHT,
    DOWN,
    DROP,
    HOLD,
    ROTATE,
    ROTATE_REV,
    WAIT
  } state_type;

  typedef enum logic {
    S_READY,
    S_ISSUED
  } sched_state_t;

  // NONE and WAIT are idle markers, never player actions worth queuing.
  function automatic logic is_action(input state_type c);
    return (c != NONE) && (c != WAIT);
  endfunction

endpackage

// File: rtl/action_fifo.sv
// First-word-fall-through command FIFO. The head is valid combinationally
// whenever the FIFO is not empty; a push into a full FIFO only succeeds when
// a pop happens in the same cycle.
module action_fifo
  import enum_type::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  state_type                din,
  output state_type                head,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] CNT_FULL = (AW + 1)'(DEPTH);
  localparam logic [AW:0] CNT_ONE  = (AW + 1)'(1);

  state_type       mem [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic            do_push;
  logic            do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CNT_FULL);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign head    = mem[rd_ptr];

  // Storage holds data only, so it carries no reset.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/action_scheduler.sv
// Buffers player commands, generates level-dependent gravity ticks and hands
// the engine exactly one action per WAIT window. Gravity has priority over
// queued commands.
module action_scheduler
  import enum_type::*;
#(
  parameter int unsigned QUEUE_DEPTH  = 8,
  parameter int unsigned GRAVITY_BASE = 100_000_000,
  parameter int unsigned LEVEL_STEP   = 6_000_000,
  parameter int unsigned GRAVITY_MIN  = 5_000_000
) (
  input  logic                           clk,
  input  logic                           reset,
  input  state_type                      cmd,
  input  logic                           cmd_valid,
  input  state_type                      state,
  input  logic [3:0]                     level,
  input  logic                           pause,
  input  logic                           clr_overflow,
  output state_type                      control,
  output logic [$clog2(QUEUE_DEPTH):0]   queue_count,
  output logic                           overflow,
  output logic                           gravity_pending
);

  // Period = max(BASE - level*STEP, MIN), evaluated without ever wrapping.
  function automatic logic [31:0] grav_period(input logic [3:0] lvl);
    logic [31:0] red;
    red = 32'(lvl) * 32'(LEVEL_STEP);
    if (red >= 32'(GRAVITY_BASE))                return 32'(GRAVITY_MIN);
    if ((32'(GRAVITY_BASE) - red) < GRAVITY_MIN) return 32'(GRAVITY_MIN);
    return 32'(GRAVITY_BASE) - red;
  endfunction

  sched_state_t  sched_q;
  logic [31:0]   grav_cnt;
  logic [31:0]   period;
  state_type     fifo_head;
  logic          fifo_full;
  logic          fifo_empty;
  logic          want_push;
  logic          can_issue;
  logic          grav_issue;
  logic          fifo_issue;
  logic          drop_cmd;
  logic          grav_tick;
  logic          soft_restart;
  logic          drop_clear;

  assign period       = grav_period(level);
  assign want_push    = cmd_valid && is_action(cmd);
  assign can_issue    = (sched_q == S_READY) && (state == WAIT) && !pause;
  assign grav_issue   = can_issue && gravity_pending;
  assign fifo_issue   = can_issue && !gravity_pending && !fifo_empty;
  assign drop_cmd     = want_push && fifo_full && !fifo_issue;
  assign grav_tick    = !pause && (grav_cnt >= period - 32'd1);
  assign soft_restart = fifo_issue && ((fifo_head == DOWN) || (fifo_head == DROP));
  assign drop_clear   = fifo_issue && (fifo_head == DROP);

  action_fifo #(
    .DEPTH (QUEUE_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (want_push),
    .pop   (fifo_issue),
    .din   (cmd),
    .head  (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (queue_count)
  );

  // Gravity timer: a player DOWN/DROP restarts the timer and suppresses a tick
  // landing on the same edge; a fresh tick outranks a gravity issue clearing it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      grav_cnt        <= '0;
      gravity_pending <= 1'b0;
    end else if (soft_restart) begin
      grav_cnt <= '0;
      if (drop_clear) gravity_pending <= 1'b0;
    end else begin
      if (!pause) grav_cnt <= grav_tick ? 32'd0 : grav_cnt + 32'd1;
      if (grav_tick)       gravity_pending <= 1'b1;
      else if (grav_issue) gravity_pending <= 1'b0;
    end
  end

  // Sticky drop flag; a drop in the clearing cycle keeps it set.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)             overflow <= 1'b0;
    else if (drop_cmd)     overflow <= 1'b1;
    else if (clr_overflow) overflow <= 1'b0;
  end

  // Issue FSM: control pulses for one cycle, then waits for the engine to leave WAIT.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sched_q <= S_READY;
      control <= NONE;
    end else begin
      control <= NONE;
      case (sched_q)
        S_READY: begin
          if (grav_issue) begin
            control <= DOWN;
            sched_q <= S_ISSUED;
          end else if (fifo_issue) begin
            control <= fifo_head;
            sched_q <= S_ISSUED;
          end
        end
        S_ISSUED: begin
          if (state != WAIT) sched_q <= S_READY;
        end
        default: sched_q <= S_READY;
      endcase
    end
  end

endmodule

// File: tb/tb_action_scheduler.sv
// Bench for action_scheduler with a small configuration (depth 4, base period
// 20, step 2, floor 4). Issued actions are matched against an expectation queue.
module tb_action_scheduler;
  import enum_type::*;

  logic        clk = 1'b0;
  logic        reset;
  state_type   cmd;
  logic        cmd_valid;
  state_type   state;
  logic [3:0]  level;
  logic        pause;
  logic        clr_overflow;
  state_type   control;
  logic [2:0]  queue_count;
  logic        overflow;
  logic        gravity_pending;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  state_type exp_q[$];
  state_type mon_exp;

  typedef struct {
    state_type cmd;
    logic      vld;
    logic      clr;
    int        exp_cnt;
    logic      exp_ovf;
  } vec_t;

  vec_t vecs[10];

  action_scheduler #(
    .QUEUE_DEPTH  (4),
    .GRAVITY_BASE (20),
    .LEVEL_STEP   (2),
    .GRAVITY_MIN  (4)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .cmd             (cmd),
    .cmd_valid       (cmd_valid),
    .state           (state),
    .level           (level),
    .pause           (pause),
    .clr_overflow    (clr_overflow),
    .control         (control),
    .queue_count     (queue_count),
    .overflow        (overflow),
    .gravity_pending (gravity_pending)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard: every non-NONE control cycle must match the next expected action.
  always @(negedge clk) begin
    if (!reset && control != NONE) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL control_unexpected: got %0d with nothing expected (cycle %0d)", control, cyc);
      end else begin
        mon_exp = exp_q.pop_front();
        if (control != mon_exp) begin
          errors++;
          $display("FAIL control_order: got %0d expected %0d (cycle %0d)", control, mon_exp, cyc);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp_v, cyc);
    end
  endtask

  task automatic push(input state_type c);
    cmd = c;
    cmd_valid = 1'b1;
    tick(1);
    cmd_valid = 1'b0;
    cmd = NONE;
  endtask

  // Engine leaves WAIT for one cycle and comes back: opens a new window.
  task automatic issue_window();
    state = NONE;
    tick(1);
    state = WAIT;
    tick(1);
  endtask

  task automatic wait_pending(input string name, output int t);
    int n;
    n = 0;
    while (gravity_pending !== 1'b1 && n < 200) begin
      tick(1);
      n++;
    end
    if (gravity_pending !== 1'b1) begin
      checks++;
      errors++;
      $display("FAIL %s: gravity_pending never rose, got %0d expected 1", name, gravity_pending);
    end
    t = cyc;
  endtask

  initial begin
    int t1, t2, t3, t4, t5, t6, t7, t8, t9, t_iss, t_rel;

    vecs[0] = '{LEFT,       1'b1, 1'b0, 1, 1'b0};
    vecs[1] = '{RIGHT,      1'b1, 1'b0, 2, 1'b0};
    vecs[2] = '{ROTATE,     1'b1, 1'b0, 3, 1'b0};
    vecs[3] = '{HOLD,       1'b1, 1'b0, 4, 1'b0};
    vecs[4] = '{DOWN,       1'b1, 1'b0, 4, 1'b1};
    vecs[5] = '{NONE,       1'b0, 1'b1, 4, 1'b0};
    vecs[6] = '{ROTATE_REV, 1'b1, 1'b1, 4, 1'b1};
    vecs[7] = '{NONE,       1'b0, 1'b1, 4, 1'b0};
    vecs[8] = '{WAIT,       1'b1, 1'b0, 4, 1'b0};
    vecs[9] = '{NONE,       1'b1, 1'b0, 4, 1'b0};

    reset = 1'b1;
    cmd = NONE;
    cmd_valid = 1'b0;
    state = WAIT;
    level = 4'd0;
    pause = 1'b0;
    clr_overflow = 1'b0;
    tick(2);
    check("rst_control", control, NONE);
    check("rst_count", queue_count, 0);
    check("rst_overflow", overflow, 0);
    check("rst_pending", gravity_pending, 0);

    // Single command: LEFT pushed on the first edge after release.
    reset = 1'b0;
    exp_q.push_back(LEFT);
    push(LEFT);
    check("t1_count_after_push", queue_count, 1);
    check("t1_control_cycle1", control, NONE);
    tick(1);
    check("t1_control_cycle2", control, LEFT);
    check("t1_count_after_pop", queue_count, 0);
    tick(1);
    check("t1_control_cycle3", control, NONE);

    // Gravity period at level 0, level 9 (floored to 4), and with a pause.
    wait_pending("t4_l0_first", t1);
    exp_q.push_back(DOWN);
    issue_window();
    check("t4_grav_down", control, DOWN);
    check("t4_pending_cleared", gravity_pending, 0);
    wait_pending("t4_l0_second", t2);
    check("t4_period_l0", t2 - t1, 20);
    level = 4'd9;
    exp_q.push_back(DOWN);
    issue_window();
    wait_pending("t4_l9_first", t3);
    check("t4_period_l9_first", t3 - t2, 4);
    exp_q.push_back(DOWN);
    issue_window();
    wait_pending("t4_l9_second", t4);
    check("t4_period_l9", t4 - t3, 4);
    level = 4'd0;
    exp_q.push_back(DOWN);
    issue_window();
    pause = 1'b1;
    tick(10);
    pause = 1'b0;
    wait_pending("t4_pause", t5);
    check("t4_period_paused", t5 - t4, 30);

    // Priority: pending gravity beats the queued RIGHT; one action per window.
    exp_q.push_back(DOWN);
    exp_q.push_back(RIGHT);
    push(RIGHT);
    check("t3_count_queued", queue_count, 1);
    issue_window();
    check("t3_first_is_down", control, DOWN);
    tick(3);
    check("t3_one_per_window", queue_count, 1);
    check("t3_control_idle", control, NONE);
    issue_window();
    check("t3_second_is_right", control, RIGHT);
    check("t3_count_empty", queue_count, 0);

    // Queued DOWN at counter 15 restarts the gravity timer.
    wait_pending("t5_sync", t6);
    exp_q.push_back(DOWN);
    issue_window();
    tick(11);
    exp_q.push_back(DOWN);
    push(DOWN);
    issue_window();
    t_iss = cyc;
    check("t5_soft_down", control, DOWN);
    wait_pending("t5_after_soft", t7);
    check("t5_soft_restart", t7 - t_iss, 20);

    // Queued DROP decided on the very edge a tick fires: no pending survives.
    exp_q.push_back(DOWN);
    issue_window();
    tick(15);
    exp_q.push_back(DROP);
    push(DROP);
    issue_window();
    t_iss = cyc;
    check("t5_drop_issued", control, DROP);
    check("t5_drop_clears_pending", gravity_pending, 0);
    issue_window();
    tick(3);
    check("t5_no_gravity_after_drop", gravity_pending, 0);
    wait_pending("t5_after_drop", t8);
    check("t5_drop_restart", t8 - t_iss, 20);
    // FSM is ready and engine is in WAIT, so this tick issues on the next edge.
    exp_q.push_back(DOWN);
    tick(1);
    check("t5_auto_down", control, DOWN);

    // Overflow and clear behaviour while paused.
    pause = 1'b1;
    foreach (vecs[i]) begin
      cmd = vecs[i].cmd;
      cmd_valid = vecs[i].vld;
      clr_overflow = vecs[i].clr;
      tick(1);
      cmd = NONE;
      cmd_valid = 1'b0;
      clr_overflow = 1'b0;
      check($sformatf("t2_vec%0d_count", i), queue_count, vecs[i].exp_cnt);
      check($sformatf("t2_vec%0d_overflow", i), overflow, vecs[i].exp_ovf);
    end
    pause = 1'b0;
    state = NONE;
    tick(1);
    // Full FIFO with a pop on the same edge: the push lands, no overflow.
    exp_q.push_back(LEFT);
    state = WAIT;
    cmd = ROTATE_REV;
    cmd_valid = 1'b1;
    tick(1);
    cmd = NONE;
    cmd_valid = 1'b0;
    check("t2_pop_push_count", queue_count, 4);
    check("t2_pop_push_overflow", overflow, 0);
    check("t2_head_left", control, LEFT);
    exp_q.push_back(RIGHT);
    issue_window();
    check("t2_order_right", control, RIGHT);
    exp_q.push_back(ROTATE);
    issue_window();
    check("t2_order_rotate", control, ROTATE);
    exp_q.push_back(HOLD);
    issue_window();
    check("t2_order_hold", control, HOLD);
    exp_q.push_back(ROTATE_REV);
    issue_window();
    check("t2_order_rotrev", control, ROTATE_REV);
    check("t2_drained", queue_count, 0);

    // Reset mid-operation: S_ISSUED, 3 queued, overflow set, action on the bus.
    wait_pending("t6_sync", t9);
    exp_q.push_back(DOWN);
    issue_window();
    push(LEFT);
    push(RIGHT);
    push(DROP);
    push(HOLD);
    push(ROTATE);
    check("t6_count_full", queue_count, 4);
    check("t6_overflow_set", overflow, 1);
    issue_window();
    check("t6_issued_left", control, LEFT);
    check("t6_count_three", queue_count, 3);
    reset = 1'b1;
    #2;
    check("t6_async_control", control, NONE);
    check("t6_async_count", queue_count, 0);
    check("t6_async_overflow", overflow, 0);
    check("t6_async_pending", gravity_pending, 0);
    tick(1);
    reset = 1'b0;
    t_rel = cyc;
    exp_q.push_back(LEFT);
    push(LEFT);
    check("t6_resume_count", queue_count, 1);
    tick(1);
    check("t6_resume_control", control, LEFT);
    wait_pending("t6_resume_gravity", t9);
    check("t6_resume_period", t9 - t_rel, 20);

    tick(2);
    check("scoreboard_drained", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
